// File: rtl/bias_relu_requant_pkg.sv
// Shared types and constants for the bias / ReLU / requantization stage.
package bias_relu_requant_pkg;

  // Default stream geometry of the convolution stage this block follows.
  localparam int DEF_IN_WIDTH    = 24;
  localparam int DEF_BIAS_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH   = 8;
  localparam int DEF_SHIFT       = 8;
  localparam int DEF_CHANNEL_NUM = 8;

  // Guard bits on top of the accumulator: one for the sign, one so that
  // accumulator + bias can never overflow.
  localparam int SUM_GUARD = 2;

  // Framing markers that travel alongside every beat.
  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } marker_t;

  // Width of an index into a table of 'depth' entries (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bias_relu_requant_rom.sv
// Small registered-read ROM holding one word per address.
// Contents arrive as a packed vector (word i at bits [i*DATA_WIDTH +: DATA_WIDTH]),
// generated from INI_FILE by the integration flow.
module bias_relu_requant_rom
  import bias_relu_requant_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 8,
  parameter     INI_FILE   = "bias_init.txt",
  parameter logic [MEM_DEPTH*DATA_WIDTH-1:0] INIT_VEC = '0
) (
  input  logic                             clk,
  input  logic [idx_width(MEM_DEPTH)-1:0]  addr_i,
  output logic [DATA_WIDTH-1:0]            data_o
);

  if (MEM_DEPTH < 1) begin : g_bad_depth
    $error("%s: MEM_DEPTH must be at least 1", INI_FILE);
  end

  logic [DATA_WIDTH-1:0] rd_d, rd_q;

  // Look up the addressed word.
  always_comb begin
    rd_d = INIT_VEC[int'(addr_i)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Register the read data (one cycle latency).
  // NOTE: ROM/datapath storage has no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
  end

  assign data_o = rd_q;

endmodule

// File: rtl/bias_relu_requant.sv
// Per-channel bias add, ReLU, round / shift / saturate of a channel-serial
// accumulator stream. Fixed three-cycle latency; markers ride with their beat.
module bias_relu_requant
  import bias_relu_requant_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int BIAS_WIDTH  = DEF_BIAS_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
  parameter     BIAS_FILE   = "bias_init.txt",
  parameter logic [CHANNEL_NUM*BIAS_WIDTH-1:0] BIAS_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic                 sop_i,
  input  logic                 eop_i,
  input  logic                 sof_i,
  input  logic                 eof_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic                 sof_o,
  output logic                 eof_o,
  output logic                 align_err_o
);

  localparam int SUM_WIDTH = IN_WIDTH + SUM_GUARD;
  localparam int CH_W      = idx_width(CHANNEL_NUM);
  localparam logic [CH_W-1:0]      CH_LAST    = CH_W'(CHANNEL_NUM - 1);
  localparam logic [OUT_WIDTH-1:0] OUT_MAX    = '1;
  localparam logic [SUM_WIDTH-1:0] ROUND_HALF = SUM_WIDTH'(1) << (SHIFT - 1);

  if (SHIFT < 1 || SHIFT > IN_WIDTH - 1) begin : g_bad_shift
    $error("bias_relu_requant: SHIFT=%0d outside 1..IN_WIDTH-1", SHIFT);
  end

  // Channel tracking and sticky alignment error.
  logic [CH_W-1:0] beat_ch, ch_d, ch_q;
  logic            align_err_d, align_err_q;

  // S0: captured input beat.
  logic                vld_s0_d, vld_s0_q;
  logic [IN_WIDTH-1:0] data_s0_d, data_s0_q;
  marker_t             mk_s0_d, mk_s0_q;
  logic [BIAS_WIDTH-1:0] bias_rd;

  // S1: biased sum (two's complement, MSB is the sign).
  logic                 vld_s1_d, vld_s1_q;
  logic [SUM_WIDTH-1:0] bias_ext, sum_s1_d, sum_s1_q;
  marker_t              mk_s1_d, mk_s1_q;

  // S2: requantized output.
  logic                 vld_o_d, vld_o_q;
  logic [SUM_WIDTH-1:0] rounded, shifted;
  logic [OUT_WIDTH-1:0] req, data_o_d, data_o_q;
  marker_t              mk_o_d, mk_o_q;

  bias_relu_requant_rom #(
    .DATA_WIDTH (BIAS_WIDTH),
    .MEM_DEPTH  (CHANNEL_NUM),
    .INI_FILE   (BIAS_FILE),
    .INIT_VEC   (BIAS_INIT)
  ) u_bias_rom (
    .clk    (clk),
    .addr_i (beat_ch),
    .data_o (bias_rd)
  );

  // Input stage: resolve the beat channel, advance the counter, flag misalignment.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    beat_ch     = (valid_i && sop_i) ? '0 : ch_q;
    ch_d        = ch_q;
    align_err_d = align_err_q;
    if (valid_i) begin
      ch_d = (beat_ch == CH_LAST) ? '0 : beat_ch + 1'b1;
      if (eop_i && (beat_ch != CH_LAST)) align_err_d = 1'b1;
      if (sop_i && (ch_q != '0))         align_err_d = 1'b1;
    end
    vld_s0_d  = valid_i;
    data_s0_d = data_i;
    mk_s0_d   = '0;
    if (valid_i) begin
      mk_s0_d.sop = sop_i;
      mk_s0_d.eop = eop_i;
      mk_s0_d.sof = sof_i;
      mk_s0_d.eof = eof_i;
    end
  end

  // Bias stage: zero-extended accumulator plus sign-extended bias.
  always_comb begin
    bias_ext = {{(SUM_WIDTH-BIAS_WIDTH){bias_rd[BIAS_WIDTH-1]}}, bias_rd};
    sum_s1_d = {{SUM_GUARD{1'b0}}, data_s0_q} + bias_ext;
    vld_s1_d = vld_s0_q;
    mk_s1_d  = mk_s0_q;
  end

  // Requant stage: ReLU, round-half-up shift, saturate; data holds between beats.
  always_comb begin
    rounded = sum_s1_q + ROUND_HALF;
    shifted = rounded >> SHIFT;
    if (sum_s1_q[SUM_WIDTH-1] || (sum_s1_q == '0)) begin
      req = '0;
    end else if (shifted > SUM_WIDTH'(OUT_MAX)) begin
      req = OUT_MAX;
    end else begin
      req = shifted[OUT_WIDTH-1:0];
    end
    data_o_d = vld_s1_q ? req : data_o_q;
    vld_o_d  = vld_s1_q;
    mk_o_d   = mk_s1_q;
  end

  // Control state and outputs; reset drops every in-flight beat.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q        <= '0;
      align_err_q <= 1'b0;
      vld_s0_q    <= 1'b0;
      mk_s0_q     <= '0;
      vld_s1_q    <= 1'b0;
      mk_s1_q     <= '0;
      vld_o_q     <= 1'b0;
      mk_o_q      <= '0;
      data_o_q    <= '0;
    end else begin
      ch_q        <= ch_d;
      align_err_q <= align_err_d;
      vld_s0_q    <= vld_s0_d;
      mk_s0_q     <= mk_s0_d;
      vld_s1_q    <= vld_s1_d;
      mk_s1_q     <= mk_s1_d;
      vld_o_q     <= vld_o_d;
      mk_o_q      <= mk_o_d;
      data_o_q    <= data_o_d;
    end
  end

  // Datapath registers; their contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    data_s0_q <= data_s0_d;
    sum_s1_q  <= sum_s1_d;
  end

  assign data_o       = data_o_q;
  assign data_valid_o = vld_o_q;
  assign sop_o        = mk_o_q.sop;
  assign eop_o        = mk_o_q.eop;
  assign sof_o        = mk_o_q.sof;
  assign eof_o        = mk_o_q.eof;
  assign align_err_o  = align_err_q;

endmodule
